// File: rtl/tqvp_segment_reader.sv
// Seven-segment reader for the TinyQV peripheral bus: debounces a segment
// pattern on ui_in, decodes it to a hex digit and queues it in a 4-entry FIFO.
module tqvp_segment_reader (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] ADDR_CTRL     = 4'h0;
    localparam logic [3:0] ADDR_STABLE   = 4'h1;
    localparam logic [3:0] ADDR_PRESCALE = 4'h2;
    localparam logic [3:0] ADDR_STATUS   = 4'h3;
    localparam logic [3:0] ADDR_HEAD     = 4'h4;
    localparam logic [3:0] ADDR_CUR      = 4'h5;
    localparam logic [3:0] ADDR_LAST     = 4'h6;

    state_t     state, state_next;
    logic       al, dp_en;
    logic [3:0] stable_n;
    logic [7:0] prescale, presc_cnt;
    logic [7:0] sync1, sync2, prev, last;
    logic [3:0] cnt, cnt_next, target;
    logic       ovf, inv;

    logic [7:0] fifo_mem [4];
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] count;

    logic       wr_ctrl, wr_stable, wr_presc, wr_status, wr_head;
    logic       run_now, tick, commit, blank, invalid, push, pop, full, push_ok;
    logic [3:0] digit;
    logic [7:0] norm, entry, head;

    assign uo_out    = 8'h00;

    assign wr_ctrl   = data_write && (address == ADDR_CTRL);
    assign wr_stable = data_write && (address == ADDR_STABLE);
    assign wr_presc  = data_write && (address == ADDR_PRESCALE);
    assign wr_status = data_write && (address == ADDR_STATUS);
    assign wr_head   = data_write && (address == ADDR_HEAD);

    always_comb begin
        state_next = state;
        if (wr_ctrl) state_next = data_in[7] ? RUN : IDLE;
    end

    // A CTRL write clearing en stops sampling on that same edge.
    assign run_now  = (state == RUN) && !(wr_ctrl && !data_in[7]);
    assign tick     = run_now && (presc_cnt == prescale);

    assign norm     = (sync2 ^ {8{al}}) & {dp_en, 7'h7F};
    assign cnt_next = (norm != prev) ? 4'd1 : ((cnt == 4'd15) ? 4'd15 : cnt + 4'd1);
    assign target   = (stable_n == 4'd0) ? 4'd1 : stable_n;
    assign commit   = tick && (cnt_next == target) && (norm != last);
    assign blank    = (norm[6:0] == 7'h00);

    // NOTE: every output of a combinational block gets a default before the case, so no latch is inferred.
    always_comb begin
        digit   = 4'h0;
        invalid = 1'b0;
        case (norm[6:0])
            7'h3F:        digit = 4'h0;
            7'h06:        digit = 4'h1;
            7'h5B:        digit = 4'h2;
            7'h4F:        digit = 4'h3;
            7'h66:        digit = 4'h4;
            7'h6D:        digit = 4'h5;
            7'h7D:        digit = 4'h6;
            7'h07, 7'h27: digit = 4'h7;
            7'h7F:        digit = 4'h8;
            7'h6F, 7'h67: digit = 4'h9;
            7'h77:        digit = 4'hA;
            7'h7C:        digit = 4'hB;
            7'h39:        digit = 4'hC;
            7'h5E:        digit = 4'hD;
            7'h79:        digit = 4'hE;
            7'h71:        digit = 4'hF;
            default:      invalid = 1'b1;
        endcase
    end

    assign entry   = {1'b1, norm[7], invalid, 1'b0, digit};
    assign full    = (count == 3'd4);
    assign push    = commit && !blank;
    assign pop     = wr_head && (count != 3'd0);
    assign push_ok = push && (!full || pop);
    assign head    = (count != 3'd0) ? fifo_mem[rd_ptr] : 8'h00;

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sync1     <= 8'h00;
            sync2     <= 8'h00;
            al        <= 1'b0;
            dp_en     <= 1'b0;
            stable_n  <= 4'd2;
            prescale  <= 8'h00;
            presc_cnt <= 8'h00;
            prev      <= 8'h00;
            cnt       <= 4'd0;
            last      <= 8'h00;
            ovf       <= 1'b0;
            inv       <= 1'b0;
            rd_ptr    <= 2'd0;
            wr_ptr    <= 2'd0;
            count     <= 3'd0;
        end else begin
            state <= state_next;
            sync1 <= ui_in;
            sync2 <= sync1;
            if (wr_ctrl)   {al, dp_en} <= data_in[6:5];
            if (wr_stable) stable_n    <= data_in[3:0];
            if (wr_presc)  prescale    <= data_in;

            if (!run_now || wr_presc || tick) presc_cnt <= 8'h00;
            else                              presc_cnt <= presc_cnt + 8'h01;

            if (!run_now) begin
                prev <= 8'h00;
                cnt  <= 4'd0;
            end else if (tick) begin
                prev <= norm;
                cnt  <= cnt_next;
            end
            if (commit) last <= norm;

            // A new event wins over a same-cycle clear so it is never lost.
            if (push && full && !pop)              ovf <= 1'b1;
            else if (wr_status && data_in[5])      ovf <= 1'b0;
            if (commit && !blank && invalid)       inv <= 1'b1;
            else if (wr_status && data_in[4])      inv <= 1'b0;

            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the FIFO storage is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= entry;
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_CTRL:     data_out = {(state == RUN), al, dp_en, 5'b0};
            ADDR_STABLE:   data_out = {4'h0, stable_n};
            ADDR_PRESCALE: data_out = prescale;
            ADDR_STATUS:   data_out = {full, (count == 3'd0), ovf, inv, 1'b0, count};
            ADDR_HEAD:     data_out = head;
            ADDR_CUR:      data_out = norm;
            ADDR_LAST:     data_out = last;
            default:       data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_segment_reader.sv
// Directed self-checking bench for tqvp_segment_reader; expected values are
// hand-computed from the segment encoding and FIFO rules.
module tb_tqvp_segment_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int n_cmp = 0;
    int n_err = 0;

    tqvp_segment_reader dut (
        .clk        (clk),
        .rst        (rst),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
        address = a;
        #1;
        d = data_out;
    endtask

    task automatic expect_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] v;
        bus_rd(a, v);
        check(tag, v, exp);
    endtask

    task automatic pop();
        bus_wr(4'h4, 8'h00);
    endtask

    task automatic hold(input logic [7:0] pat, input int clocks);
        @(posedge clk);
        #1 ui_in = pat;
        repeat (clocks) @(posedge clk);
        #1;
    endtask

    logic [7:0] digits6 [6] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D};
    logic [7:0] fill4   [4] = '{8'h07, 8'h7F, 8'h77, 8'h7C};

    initial begin
        rst        = 1'b1;
        ui_in      = 8'h00;
        address    = 4'h0;
        data_write = 1'b0;
        data_in    = 8'h00;
        #2;
        expect_reg("reset_status", 4'h3, 8'h40);
        expect_reg("reset_head", 4'h4, 8'h00);
        expect_reg("reset_stable", 4'h1, 8'h02);
        check("reset_uo_out", uo_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Latency: P=0, N=3, count rises after edge 5 and not before.
        bus_wr(4'h2, 8'h00);
        bus_wr(4'h1, 8'h03);
        bus_wr(4'h0, 8'h80);
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1 ui_in = 8'h4F;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            expect_reg($sformatf("latency_edge%0d", e), 4'h3, (e == 5) ? 8'h01 : 8'h40);
        end
        expect_reg("first_head", 4'h4, 8'h83);

        // No duplicates; blank commits update LAST only.
        hold(8'h4F, 100);
        expect_reg("no_dup", 4'h3, 8'h01);
        hold(8'h00, 10);
        expect_reg("blank_last", 4'h6, 8'h00);
        expect_reg("blank_no_push", 4'h3, 8'h01);
        hold(8'h4F, 10);
        expect_reg("second_push", 4'h3, 8'h02);
        expect_reg("last_4f", 4'h6, 8'h4F);
        expect_reg("dup_head0", 4'h4, 8'h83);
        pop();
        expect_reg("dup_head1", 4'h4, 8'h83);
        pop();
        expect_reg("drained", 4'h3, 8'h40);

        // Active-low input with dp, variant 9 and an invalid pattern.
        bus_wr(4'h0, 8'h00);
        ui_in = 8'h18;
        repeat (3) @(posedge clk);
        bus_wr(4'h0, 8'hE0);
        hold(8'h18, 10);
        expect_reg("al_dp_head", 4'h4, 8'hC9);
        hold(8'hB6, 10);
        expect_reg("cur_norm", 4'h5, 8'h49);
        expect_reg("inv_status", 4'h3, 8'h12);
        bus_wr(4'h3, 8'h10);
        expect_reg("inv_cleared", 4'h3, 8'h02);
        expect_reg("al_head0", 4'h4, 8'hC9);
        pop();
        expect_reg("invalid_head", 4'h4, 8'hA0);
        pop();
        expect_reg("al_drained", 4'h3, 8'h40);

        // Overflow: six digits into a four-entry FIFO.
        bus_wr(4'h0, 8'h00);
        ui_in = 8'h00;
        repeat (3) @(posedge clk);
        bus_wr(4'h0, 8'h80);
        for (int i = 0; i < 6; i++) hold(digits6[i], 10);
        expect_reg("full_status", 4'h3, 8'hA4);
        for (int i = 0; i < 4; i++) begin
            expect_reg($sformatf("ovf_head%0d", i), 4'h4, 8'h80 + 8'(i));
            pop();
        end
        expect_reg("empty_status", 4'h3, 8'h60);
        expect_reg("empty_head", 4'h4, 8'h00);
        pop();
        expect_reg("pop_empty", 4'h3, 8'h60);
        bus_wr(4'h3, 8'h20);
        expect_reg("ovf_cleared", 4'h3, 8'h40);

        // Glitch rejection with P=3, N=2.
        bus_wr(4'h2, 8'h03);
        bus_wr(4'h1, 8'h02);
        hold(8'h06, 40);
        @(posedge clk);
        #1 ui_in = 8'h7F;
        repeat (3) @(posedge clk);
        #1 ui_in = 8'h5B;
        repeat (40) @(posedge clk);
        #1;
        expect_reg("glitch_count", 4'h3, 8'h02);
        expect_reg("glitch_head0", 4'h4, 8'h81);
        pop();
        expect_reg("glitch_head1", 4'h4, 8'h82);
        pop();

        // Simultaneous pop and push while full.
        bus_wr(4'h2, 8'h00);
        bus_wr(4'h1, 8'h03);
        for (int i = 0; i < 4; i++) hold(fill4[i], 10);
        expect_reg("fill_status", 4'h3, 8'h84);
        @(posedge clk);
        #1 ui_in = 8'h39;
        repeat (4) @(posedge clk);
        #1;
        address    = 4'h4;
        data_write = 1'b1;
        @(posedge clk);
        #1 data_write = 1'b0;
        expect_reg("pushpop_status", 4'h3, 8'h84);
        expect_reg("pushpop_head", 4'h4, 8'h88);

        // Asynchronous reset mid-stream.
        ui_in = 8'h71;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        expect_reg("async_rst_status", 4'h3, 8'h40);
        expect_reg("async_rst_head", 4'h4, 8'h00);
        expect_reg("async_rst_last", 4'h6, 8'h00);
        expect_reg("async_rst_ctrl", 4'h0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        expect_reg("post_rst_stable", 4'h1, 8'h02);
        check("post_rst_uo_out", uo_out, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish within 200000");
        $fatal(1);
    end

endmodule
